// File: rtl/ex_mem_ctl_pkg.sv
// Package: ex_mem_ctl_pkg
// Shared constants and helpers for the Y86 EX->MEM pipeline register.
//   - Default field widths (byte / word).
//   - Y86 encodings used by the bubble image: INOP, RNONE, SBUB, SAOK.
//   - Per-edge control action enum and its priority decoder.
//   - Event counter indices for the generate loop in the top.
package ex_mem_ctl_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W_DEF = 32;
    localparam int STAT_W_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    // Y86 encodings; the top casts them to its configured field widths.
    localparam int unsigned INOP  = 1;
    localparam logic [3:0]  RNONE = 4'hF;
    localparam int unsigned SBUB  = 0;
    localparam int unsigned SAOK  = 1;

    // What the register does on a given edge.
    typedef enum logic [1:0] {
        CTL_LOAD   = 2'd0,
        CTL_STALL  = 2'd1,
        CTL_BUBBLE = 2'd2,
        CTL_RESET  = 2'd3
    } ctl_e;

    // Event counter slots.
    localparam int EV_STALL  = 0;
    localparam int EV_BUBBLE = 1;
    localparam int EV_NUM    = 2;

    // Priority: rst > bubble > stall > load.
    function automatic ctl_e decode_ctl(input logic rst, input logic stall, input logic bubble);
        ctl_e c;
        if (rst)
            c = CTL_RESET;
        else if (bubble)
            c = CTL_BUBBLE;
        else if (stall)
            c = CTL_STALL;
        else
            c = CTL_LOAD;
        return c;
    endfunction

endpackage

// File: rtl/ex_mem_ctl_if.sv
// Interface: ex_mem_ctl_if
// Bundles the EX->MEM register's data and control signals.
//   master : execute stage / hazard unit side (drives ex_* and control, reads mem_* and status)
//   slave  : the pipeline register itself
// Signals:
//   M_stall, M_bubble         control bits for this edge
//   ex_*  / e_Cnd_i           E-stage fields
//   mem_* / M_Cnd_o           registered M-stage fields
//   stall_cnt, bubble_cnt     saturating event counters
//   ctl_err                   sticky stall+bubble conflict flag
interface ex_mem_ctl_if
    import ex_mem_ctl_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int ICODE_W = BYTE_W,
    parameter int REGID_W = BYTE_W,
    parameter int STAT_W  = STAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic               M_stall;
    logic               M_bubble;

    logic [ICODE_W-1:0] ex_icode;
    logic [WORD_W-1:0]  ex_valA;
    logic [WORD_W-1:0]  ex_valP;
    logic [WORD_W-1:0]  ex_valE;
    logic [REGID_W-1:0] ex_dstE;
    logic [REGID_W-1:0] ex_dstM;
    logic               e_Cnd_i;
    logic [STAT_W-1:0]  ex_stat;

    logic [ICODE_W-1:0] mem_icode;
    logic [WORD_W-1:0]  mem_valA;
    logic [WORD_W-1:0]  mem_valP;
    logic [WORD_W-1:0]  mem_valE;
    logic [REGID_W-1:0] mem_dstE;
    logic [REGID_W-1:0] mem_dstM;
    logic               M_Cnd_o;
    logic [STAT_W-1:0]  mem_stat;

    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
    logic               ctl_err;

    modport master (
        output M_stall, M_bubble,
        output ex_icode, ex_valA, ex_valP, ex_valE, ex_dstE, ex_dstM, e_Cnd_i, ex_stat,
        input  mem_icode, mem_valA, mem_valP, mem_valE, mem_dstE, mem_dstM, M_Cnd_o, mem_stat,
        input  stall_cnt, bubble_cnt, ctl_err
    );

    modport slave (
        input  M_stall, M_bubble,
        input  ex_icode, ex_valA, ex_valP, ex_valE, ex_dstE, ex_dstM, e_Cnd_i, ex_stat,
        output mem_icode, mem_valA, mem_valP, mem_valE, mem_dstE, mem_dstM, M_Cnd_o, mem_stat,
        output stall_cnt, bubble_cnt, ctl_err
    );

endinterface

// File: rtl/ex_mem_ctl_sat_counter.sv
// Module: sat_counter
// Saturating up-counter: increments on each edge with inc high, sticks at
// all-ones, clears on synchronous active-high rst.
// Ports:
//   clk    in   1      clock
//   rst    in   1      synchronous active-high reset
//   inc    in   1      count this edge
//   count  out  CNT_W  current count (registered)
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst)
            count_reg <= '0;
        else if (inc && (count_reg != {CNT_W{1'b1}}))
            count_reg <= count_reg + 1'b1;
    end

    assign count = count_reg;

endmodule

// File: rtl/ex_mem_ctl.sv
// Module: ex_mem_ctl
// Y86 EX->MEM pipeline register with stall/bubble control, saturating
// stall/bubble event counters and a sticky stall+bubble conflict flag.
// Ports:
//   clk   in     1                  clock, all state on posedge
//   rst   in     1                  synchronous active-high reset (loads bubble image)
//   bus   slave  ex_mem_ctl_if      control, ex_* inputs, mem_* outputs, counters, ctl_err
// Every output comes straight from a flop.
module ex_mem_ctl
    import ex_mem_ctl_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int ICODE_W = BYTE_W,
    parameter int REGID_W = BYTE_W,
    parameter int STAT_W  = STAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_ctl_if.slave  bus
);

    // Bubble image values at the configured widths.
    localparam logic [ICODE_W-1:0] ICODE_NOP  = ICODE_W'(INOP);
    localparam logic [REGID_W-1:0] REG_NONE   = REGID_W'(RNONE);
    localparam logic [STAT_W-1:0]  STAT_BUB   = STAT_W'(SBUB);

    ctl_e ctl;

    logic [ICODE_W-1:0] icode_reg;
    logic [WORD_W-1:0]  val_a_reg;
    logic [WORD_W-1:0]  val_p_reg;
    logic [WORD_W-1:0]  val_e_reg;
    logic [REGID_W-1:0] dst_e_reg;
    logic [REGID_W-1:0] dst_m_reg;
    logic               cnd_reg;
    logic [STAT_W-1:0]  stat_reg;
    logic               ctl_err_reg;

    logic [EV_NUM-1:0]  cnt_inc;
    logic [CNT_W-1:0]   cnt_val [EV_NUM];

    always_comb begin
        ctl = decode_ctl(rst, bus.M_stall, bus.M_bubble);
    end

    // Only the applied action counts: a stall that loses to a bubble is not a stall.
    always_comb begin
        cnt_inc            = '0;
        cnt_inc[EV_STALL]  = (ctl == CTL_STALL);
        cnt_inc[EV_BUBBLE] = (ctl == CTL_BUBBLE);
    end

    always_ff @(posedge clk) begin
        case (ctl)
            CTL_RESET, CTL_BUBBLE: begin
                icode_reg <= ICODE_NOP;
                val_a_reg <= '0;
                val_p_reg <= '0;
                val_e_reg <= '0;
                dst_e_reg <= REG_NONE;
                dst_m_reg <= REG_NONE;
                cnd_reg   <= 1'b0;
                stat_reg  <= STAT_BUB;
            end
            CTL_LOAD: begin
                icode_reg <= bus.ex_icode;
                val_a_reg <= bus.ex_valA;
                val_p_reg <= bus.ex_valP;
                val_e_reg <= bus.ex_valE;
                dst_e_reg <= bus.ex_dstE;
                dst_m_reg <= bus.ex_dstM;
                cnd_reg   <= bus.e_Cnd_i;
                stat_reg  <= bus.ex_stat;
            end
            default: begin
                // CTL_STALL: every field holds.
            end
        endcase
    end

    // Conflict is flagged on the raw control bits, then held until reset.
    always_ff @(posedge clk) begin
        if (rst)
            ctl_err_reg <= 1'b0;
        else if (bus.M_stall && bus.M_bubble)
            ctl_err_reg <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < EV_NUM; gi++) begin : g_ev_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.mem_icode  = icode_reg;
    assign bus.mem_valA   = val_a_reg;
    assign bus.mem_valP   = val_p_reg;
    assign bus.mem_valE   = val_e_reg;
    assign bus.mem_dstE   = dst_e_reg;
    assign bus.mem_dstM   = dst_m_reg;
    assign bus.M_Cnd_o    = cnd_reg;
    assign bus.mem_stat   = stat_reg;
    assign bus.stall_cnt  = cnt_val[EV_STALL];
    assign bus.bubble_cnt = cnt_val[EV_BUBBLE];
    assign bus.ctl_err    = ctl_err_reg;

endmodule

// File: tb/tb_ex_mem_ctl.sv
// Testbench: tb_ex_mem_ctl
// Directed vectors for ex_mem_ctl with CNT_W=4 so saturation is reachable quickly.
module tb_ex_mem_ctl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_mem_ctl_if #(.WORD_W(32), .ICODE_W(8), .REGID_W(8), .STAT_W(3), .CNT_W(CW)) bus ();

    ex_mem_ctl #(
        .WORD_W(32), .ICODE_W(8), .REGID_W(8), .STAT_W(3), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] icode, input logic [31:0] va, input logic [31:0] vp,
                         input logic [31:0] ve, input logic [7:0] de, input logic [7:0] dm,
                         input logic cnd, input logic [2:0] st);
        bus.ex_icode = icode;
        bus.ex_valA  = va;
        bus.ex_valP  = vp;
        bus.ex_valE  = ve;
        bus.ex_dstE  = de;
        bus.ex_dstM  = dm;
        bus.e_Cnd_i  = cnd;
        bus.ex_stat  = st;
    endtask

    task automatic check_fields(input string tag, input logic [7:0] icode, input logic [31:0] va,
                                input logic [31:0] vp, input logic [31:0] ve, input logic [7:0] de,
                                input logic [7:0] dm, input logic cnd, input logic [2:0] st);
        check_eq({tag, ".icode"}, 64'(bus.mem_icode), 64'(icode));
        check_eq({tag, ".valA"},  64'(bus.mem_valA),  64'(va));
        check_eq({tag, ".valP"},  64'(bus.mem_valP),  64'(vp));
        check_eq({tag, ".valE"},  64'(bus.mem_valE),  64'(ve));
        check_eq({tag, ".dstE"},  64'(bus.mem_dstE),  64'(de));
        check_eq({tag, ".dstM"},  64'(bus.mem_dstM),  64'(dm));
        check_eq({tag, ".Cnd"},   64'(bus.M_Cnd_o),   64'(cnd));
        check_eq({tag, ".stat"},  64'(bus.mem_stat),  64'(st));
    endtask

    // Bubble image: icode=1 (nop), dst=0x0F, stat=0, Cnd=0, values 0.
    task automatic check_image(input string tag);
        check_fields(tag, 8'h01, 32'h0, 32'h0, 32'h0, 8'h0F, 8'h0F, 1'b0, 3'd0);
    endtask

    task automatic check_status(input string tag, input logic [3:0] sc, input logic [3:0] bc,
                                input logic err);
        check_eq({tag, ".stall_cnt"},  64'(bus.stall_cnt),  64'(sc));
        check_eq({tag, ".bubble_cnt"}, 64'(bus.bubble_cnt), 64'(bc));
        check_eq({tag, ".ctl_err"},    64'(bus.ctl_err),    64'(err));
    endtask

    initial begin
        // 1. Reset with arbitrary inputs and both control bits asserted.
        rst          = 1'b1;
        bus.M_stall  = 1'b1;
        bus.M_bubble = 1'b1;
        drive(8'hA5, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 8'h07, 8'h02, 1'b1, 3'd4);
        step();
        check_image("reset");
        check_status("reset", 4'd0, 4'd0, 1'b0);

        // 2. Pass-through.
        rst          = 1'b0;
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        drive(8'h60, 32'h1234_5678, 32'h0000_0100, 32'hDEAD_BEEF, 8'h03, 8'h0F, 1'b1, 3'd1);
        step();
        check_fields("pass", 8'h60, 32'h1234_5678, 32'h0000_0100, 32'hDEAD_BEEF, 8'h03, 8'h0F, 1'b1, 3'd1);
        check_status("pass", 4'd0, 4'd0, 1'b0);

        // 3. Load valE=0x11, then stall 3 cycles while inputs move on.
        drive(8'h30, 32'hA, 32'hB, 32'h11, 8'h04, 8'h05, 1'b0, 3'd1);
        step();
        check_eq("stall.pre.valE", 64'(bus.mem_valE), 64'h11);
        drive(8'h40, 32'hC, 32'hD, 32'h22, 8'h06, 8'h07, 1'b1, 3'd2);
        bus.M_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall%0d.valE", i), 64'(bus.mem_valE), 64'h11);
            check_eq($sformatf("stall%0d.icode", i), 64'(bus.mem_icode), 64'h30);
            check_eq($sformatf("stall%0d.dstE", i), 64'(bus.mem_dstE), 64'h04);
            check_eq($sformatf("stall%0d.stall_cnt", i), 64'(bus.stall_cnt), 64'(i + 1));
        end
        bus.M_stall = 1'b0;
        step();
        check_fields("release", 8'h40, 32'hC, 32'hD, 32'h22, 8'h06, 8'h07, 1'b1, 3'd2);
        check_status("release", 4'd3, 4'd0, 1'b0);

        // 4. Bubble pulse discards the valid data sitting on the inputs.
        drive(8'h50, 32'h77, 32'h88, 32'h99, 8'h01, 8'h02, 1'b1, 3'd1);
        bus.M_bubble = 1'b1;
        step();
        check_image("bubble");
        check_status("bubble", 4'd3, 4'd1, 1'b0);
        bus.M_bubble = 1'b0;
        step();
        check_fields("after_bub", 8'h50, 32'h77, 32'h88, 32'h99, 8'h01, 8'h02, 1'b1, 3'd1);

        // 5. Conflict: bubble wins, only bubble counted, ctl_err sticks.
        drive(8'h70, 32'h1, 32'h2, 32'h3, 8'h08, 8'h09, 1'b1, 3'd1);
        bus.M_stall  = 1'b1;
        bus.M_bubble = 1'b1;
        step();
        check_image("conflict");
        check_status("conflict", 4'd3, 4'd2, 1'b1);
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("sticky%0d.ctl_err", i), 64'(bus.ctl_err), 64'h1);
        end
        check_fields("post_conf", 8'h70, 32'h1, 32'h2, 32'h3, 8'h08, 8'h09, 1'b1, 3'd1);

        // 6. Saturation: stall 20 cycles from stall_cnt=3, limit 15.
        drive(8'hB0, 32'hF0, 32'hF1, 32'hF2, 8'h0A, 8'h0B, 1'b0, 3'd3);
        bus.M_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq($sformatf("sat%0d.stall_cnt", i), 64'(bus.stall_cnt),
                     64'(((4 + i) > 15) ? 15 : (4 + i)));
        end
        check_eq("sat.valE_held", 64'(bus.mem_valE), 64'h3);

        // Reset during the stall: reset wins, everything clears.
        rst = 1'b1;
        step();
        check_image("rst_stall");
        check_status("rst_stall", 4'd0, 4'd0, 1'b0);
        rst = 1'b0;
        step();
        check_image("stall_after_rst");
        check_status("stall_after_rst", 4'd1, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
